// File: rtl/dem_tree_pkg.sv
// Shared types, constants and helpers for the tree-structured DEM encoder.
package dem_tree_pkg;

  typedef enum logic [1:0] {
    DEM_THERM  = 2'd0,
    DEM_RANDOM = 2'd1,
    DEM_SHAPE  = 2'd2,
    DEM_RSVD   = 2'd3
  } dem_mode_e;

  localparam int LFSR_W     = 15;
  // x^15 + x^14 + 1 expressed as bit positions of a left-shifting register
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;
  localparam int MAX_LEVELS = 4;

  // Every internal node needs its own PN bit, so NE-1 must not exceed LFSR_W.
  function automatic bit levels_ok(input int levels);
    return (levels >= 1) && (levels <= MAX_LEVELS);
  endfunction

  function automatic int clamp_code(input int x, input int ne);
    return (x > ne) ? ne : x;
  endfunction

  // Bit offset of pipeline stage 'stage' in the flat stage vector.
  function automatic int stage_off(input int levels, input int stage);
    int acc;
    acc = 0;
    for (int i = 0; i < stage; i++) acc += (1 << i) * (levels + 1 - i);
    return acc;
  endfunction

endpackage

// File: rtl/dem_switch_node.sv
// One DEM switching node: splits x into x1 + x2 with the odd remainder steered by mode.
module dem_switch_node
  import dem_tree_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  input  dem_mode_e    i_mode,
  input  logic         i_rnd,
  input  logic         i_st,
  output logic [W-2:0] o_x1,
  output logic [W-2:0] o_x2,
  output logic         o_odd
);

  logic         w_pos;
  logic [W-2:0] w_half;
  logic [W-2:0] w_up;

  always_comb begin
    w_pos = 1'b1;
    case (i_mode)
      DEM_RANDOM: w_pos = i_rnd;
      DEM_SHAPE:  w_pos = ~i_st;
      default:    w_pos = 1'b1;
    endcase
  end

  // For even x both halves are equal, so the sign only matters when x is odd.
  assign w_half = i_x[W-1:1];
  assign w_up   = w_half + (W-1)'(i_x[0]);
  assign o_x1   = w_pos ? w_up : w_half;
  assign o_x2   = w_pos ? w_half : w_up;
  assign o_odd  = i_x[0];

endmodule

// File: rtl/dem_tree_encoder.sv
// Pipelined tree DEM encoder: clamps the code, splits it over LEVELS node levels,
// and drives 2^LEVELS unit elements whose popcount equals the clamped code.
module dem_tree_encoder
  import dem_tree_pkg::*;
#(
  parameter int          LEVELS    = 3,
  parameter logic [14:0] LFSR_SEED = 15'h4A5F
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic [LEVELS:0]        x_in_i,
  input  logic [1:0]             mode_i,
  output logic                   valid_o,
  output logic [(1<<LEVELS)-1:0] elem_o,
  output logic                   ovf_o
);

  localparam int NE       = 1 << LEVELS;
  localparam int TOT      = stage_off(LEVELS, LEVELS + 1);
  localparam int OFF_LEAF = stage_off(LEVELS, LEVELS);
  localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == 15'h0000) ? 15'h0001 : LFSR_SEED;

  if (!levels_ok(LEVELS)) begin : g_bad_levels
    $error("dem_tree_encoder: LEVELS must be within 1..4");
  end

  logic [TOT-1:0]    r_stage;
  logic [TOT-1:0]    w_stage_d;
  logic [LEVELS+1:0] r_vld;
  logic [LEVELS+1:0] r_ovf;
  dem_mode_e         r_mode [LEVELS];
  logic [NE-1:1]     r_st;
  logic [NE-1:1]     w_tog;
  logic [LFSR_W-1:0] r_lfsr;
  logic [NE-1:0]     r_elem;
  logic              w_ovf;
  logic [LEVELS:0]   w_code;

  assign w_ovf                = int'(x_in_i) > NE;
  assign w_code               = (LEVELS+1)'(clamp_code(int'(x_in_i), NE));
  assign w_stage_d[LEVELS:0]  = valid_i ? w_code : '0;

  // Node level l reads stage l and writes stage l+1; stage LEVELS holds the element bits.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int W       = LEVELS + 1 - l;
    localparam int OFF_IN  = stage_off(LEVELS, l);
    localparam int OFF_OUT = stage_off(LEVELS, l + 1);
    for (genvar j = 0; j < (1 << l); j++) begin : g_node
      localparam int N = (1 << l) + j;
      logic w_odd;
      dem_switch_node #(.W(W)) u_node (
        .i_x   (r_stage[OFF_IN + j*W +: W]),
        .i_mode(r_mode[l]),
        .i_rnd (r_lfsr[N-1]),
        .i_st  (r_st[N]),
        .o_x1  (w_stage_d[OFF_OUT + (2*j)*(W-1) +: W-1]),
        .o_x2  (w_stage_d[OFF_OUT + (2*j+1)*(W-1) +: W-1]),
        .o_odd (w_odd)
      );
      assign w_tog[N] = w_odd & r_vld[l] & (r_mode[l] == DEM_SHAPE);
    end
  end

  // Data, valid and overflow pipeline plus the registered element outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_stage <= '0;
      r_vld   <= '0;
      r_ovf   <= '0;
      r_elem  <= '0;
    end else begin
      r_stage <= w_stage_d;
      r_vld   <= {r_vld[LEVELS:0], valid_i};
      r_ovf   <= {r_ovf[LEVELS:0], valid_i & w_ovf};
      r_elem  <= r_stage[OFF_LEAF +: NE];
    end
  end

  // Mode rides along with its sample so each level uses that sample's mode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < LEVELS; i++) r_mode[i] <= DEM_THERM;
    end else begin
      r_mode[0] <= valid_i ? dem_mode_e'(mode_i) : DEM_THERM;
      for (int i = 1; i < LEVELS; i++) r_mode[i] <= r_mode[i-1];
    end
  end

  // Noise-shaping node state and free-running PN generator.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_st   <= '0;
      r_lfsr <= LFSR_INIT;
    end else begin
      r_st   <= r_st ^ w_tog;
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
    end
  end

  assign valid_o = r_vld[LEVELS+1];
  assign ovf_o   = r_ovf[LEVELS+1];
  assign elem_o  = r_elem;

endmodule

// File: tb/tb_dem_tree_encoder.sv
// Directed self-checking bench for dem_tree_encoder with LEVELS=3 (8 elements).
module tb_dem_tree_encoder;
  import dem_tree_pkg::*;

  localparam int NRAND = 4000;
  localparam logic [7:0] THERM_TAB [9] = '{8'h00, 8'h01, 8'h11, 8'h15, 8'h55,
                                            8'h57, 8'h77, 8'h7F, 8'hFF};
  localparam logic [7:0] SHAPE_TAB [8] = '{8'h01, 8'h10, 8'h04, 8'h40,
                                            8'h02, 8'h20, 8'h08, 8'h80};
  localparam int IL_CODES [8] = '{3, 6, 1, 7, 2, 5, 4, 8};

  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic [3:0] x_in_i;
  logic [1:0] mode_i;
  logic       valid_o;
  logic [7:0] elem_o;
  logic       ovf_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_elem [$];
  logic       q_ovf  [$];
  logic [3:0] rnd_code [NRAND];
  int         rnd_gap  [NRAND];
  logic [7:0] run1     [NRAND];

  dem_tree_encoder #(.LEVELS(3), .LFSR_SEED(15'h4A5F)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .x_in_i (x_in_i),
    .mode_i (mode_i),
    .valid_o(valid_o),
    .elem_o (elem_o),
    .ovf_o  (ovf_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      q_elem.push_back(elem_o);
      q_ovf.push_back(ovf_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    x_in_i  = 4'd0;
    mode_i  = 2'd0;
  endtask

  task automatic drive(input logic [3:0] x, input logic [1:0] m);
    valid_i = 1'b1;
    x_in_i  = x;
    mode_i  = m;
    step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle();
    step();
    step();
    reset_i = 1'b0;
    q_elem.delete();
    q_ovf.delete();
  endtask

  task automatic wait_outputs(input int n);
    for (int c = 0; c < 300 && q_elem.size() < n; c++) step();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    valid_i = 1'b1;
    x_in_i  = 4'd5;
    mode_i  = DEM_THERM;
    step();
    step();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++;
    if (elem_o !== 8'h00) begin errors++; $display("FAIL reset_elem got=%h exp=00", elem_o); end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    reset_i = 1'b0;
    idle();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_drop cyc=%0d valid=%b exp=0", c, valid_o); end
    end
  endtask

  task automatic test_therm();
    do_reset();
    drive(4'd5, DEM_THERM);
    idle();
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (valid_o !== (c == 4)) begin
        errors++; $display("FAIL therm_latency cyc=%0d valid=%b exp=%b", c, valid_o, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (elem_o !== 8'h57) begin errors++; $display("FAIL therm_x5 got=%h exp=57", elem_o); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("FAIL therm_x5_ovf got=%b exp=0", ovf_o); end
      end
    end
    step();
    q_elem.delete();
    q_ovf.delete();
    drive(4'd0, DEM_THERM);
    drive(4'd8, DEM_THERM);
    drive(4'd9, DEM_THERM);
    drive(4'd5, DEM_RSVD);
    idle();
    wait_outputs(4);
    checks++;
    if (q_elem.size() != 4) begin errors++; $display("FAIL therm_count got=%0d exp=4", q_elem.size()); end
    for (int i = 0; i < 4 && i < q_elem.size(); i++) begin
      logic [7:0] exp_e;
      logic       exp_o;
      exp_e = (i == 0) ? 8'h00 : (i == 3) ? 8'h57 : 8'hFF;
      exp_o = (i == 2);
      checks++;
      if (q_elem[i] !== exp_e) begin errors++; $display("FAIL therm_elem idx=%0d got=%h exp=%h", i, q_elem[i], exp_e); end
      checks++;
      if (q_ovf[i] !== exp_o) begin errors++; $display("FAIL therm_ovf idx=%0d got=%b exp=%b", i, q_ovf[i], exp_o); end
    end
  endtask

  task automatic test_shape();
    do_reset();
    for (int i = 0; i < 16; i++) drive(4'd1, DEM_SHAPE);
    idle();
    wait_outputs(16);
    checks++;
    if (q_elem.size() != 16) begin errors++; $display("FAIL shape_count got=%0d exp=16", q_elem.size()); end
    for (int i = 0; i < 16 && i < q_elem.size(); i++) begin
      checks++;
      if (q_elem[i] !== SHAPE_TAB[i % 8]) begin
        errors++; $display("FAIL shape_seq idx=%0d got=%h exp=%h", i, q_elem[i], SHAPE_TAB[i % 8]);
      end
    end
  endtask

  task automatic run_random(input int pass);
    int cnt [8];
    int total;
    int dev;
    do_reset();
    for (int i = 0; i < NRAND; i++) begin
      for (int g = 0; g < rnd_gap[i]; g++) begin
        idle();
        step();
      end
      drive(rnd_code[i], DEM_RANDOM);
    end
    idle();
    wait_outputs(NRAND);
    checks++;
    if (q_elem.size() != NRAND) begin errors++; $display("FAIL random_count pass=%0d got=%0d exp=%0d", pass, q_elem.size(), NRAND); end
    for (int e = 0; e < 8; e++) cnt[e] = 0;
    total = 0;
    for (int i = 0; i < NRAND && i < q_elem.size(); i++) begin
      checks++;
      if ($countones(q_elem[i]) != int'(rnd_code[i])) begin
        errors++; $display("FAIL random_popcount idx=%0d got=%h exp_ones=%0d", i, q_elem[i], rnd_code[i]);
      end
      for (int e = 0; e < 8; e++) cnt[e] += int'(q_elem[i][e]);
      total += int'(rnd_code[i]);
      if (pass == 0) begin
        run1[i] = q_elem[i];
      end else begin
        checks++;
        if (q_elem[i] !== run1[i]) begin errors++; $display("FAIL random_repeat idx=%0d got=%h exp=%h", i, q_elem[i], run1[i]); end
      end
    end
    if (pass == 0) begin
      for (int e = 0; e < 8; e++) begin
        dev = 8 * cnt[e] - total;
        if (dev < 0) dev = -dev;
        checks++;
        if (dev * 20 > total) begin
          errors++; $display("FAIL random_balance elem=%0d got=%0d exp=%0d+-5%%", e, cnt[e], total / 8);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NRAND; i++) begin
      rnd_code[i] = 4'($urandom_range(8, 0));
      rnd_gap[i]  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
    end
    run_random(0);
    run_random(1);
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'(IL_CODES[i]), DEM_THERM);
      drive(4'd1, DEM_SHAPE);
    end
    idle();
    wait_outputs(16);
    checks++;
    if (q_elem.size() != 16) begin errors++; $display("FAIL interleave_count got=%0d exp=16", q_elem.size()); end
    for (int i = 0; i < 8 && 2*i+1 < q_elem.size(); i++) begin
      checks++;
      if (q_elem[2*i] !== THERM_TAB[IL_CODES[i]]) begin
        errors++; $display("FAIL interleave_therm idx=%0d got=%h exp=%h", i, q_elem[2*i], THERM_TAB[IL_CODES[i]]);
      end
      checks++;
      if (q_elem[2*i+1] !== SHAPE_TAB[i]) begin
        errors++; $display("FAIL interleave_shape idx=%0d got=%h exp=%h", i, q_elem[2*i+1], SHAPE_TAB[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(4'd1, DEM_SHAPE);
    drive(4'd1, DEM_SHAPE);
    drive(4'd1, DEM_SHAPE);
    idle();
    reset_i = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", valid_o); end
    reset_i = 1'b0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (q_elem.size() != 0) begin errors++; $display("FAIL midreset_flush got=%0d exp=0", q_elem.size()); end
    drive(4'd1, DEM_SHAPE);
    idle();
    wait_outputs(1);
    checks++;
    if (q_elem.size() != 1) begin
      errors++; $display("FAIL midreset_count got=%0d exp=1", q_elem.size());
    end else begin
      checks++;
      if (q_elem[0] !== 8'h01) begin errors++; $display("FAIL midreset_shape got=%h exp=01", q_elem[0]); end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    test_reset();
    test_therm();
    test_shape();
    test_random();
    test_interleave();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
